// File: rtl/prog_sync_fifo.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a selectable first-word-fall-through read port.
module prog_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int AF_LEVEL   = (2**ADDR_WIDTH) - 4,
  parameter int AE_LEVEL   = 4,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_req,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   fill_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT   = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_CNT   = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0] ONE      = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr_reg;
  logic [ADDR_WIDTH:0]   rd_ptr_reg;
  logic [ADDR_WIDTH:0]   count_reg;
  logic                  overflow_reg;
  logic                  underflow_reg;
  logic                  wr_ok;
  logic                  rd_ok;

  // Acceptance is judged on the pre-edge flags, so a full FIFO still drains
  // and an empty FIFO still fills when both requests arrive together.
  assign wr_ok = wr_req && !fifo_full;
  assign rd_ok = rd_req && !fifo_empty;

  assign fifo_full    = (count_reg == FULL_CNT);
  assign fifo_empty   = (count_reg == '0);
  assign almost_full  = (count_reg >= AF_CNT);
  assign almost_empty = (count_reg <= AE_CNT);
  assign fill_count   = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[wr_ptr_reg[ADDR_WIDTH-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + ONE;
      if (rd_ok) rd_ptr_reg <= rd_ptr_reg + ONE;
      if (wr_ok && !rd_ok)      count_reg <= count_reg + ONE;
      else if (rd_ok && !wr_ok) count_reg <= count_reg - ONE;
      // A fresh error in the clearing cycle must survive the clear.
      if (wr_req && fifo_full) overflow_reg <= 1'b1;
      else if (clr_err)        overflow_reg <= 1'b0;
      if (rd_req && fifo_empty) underflow_reg <= 1'b1;
      else if (clr_err)         underflow_reg <= 1'b0;
    end
  end

  generate
    if (FWFT == 0) begin : g_std
      logic [DATA_WIDTH-1:0] dout_reg;
      logic                  valid_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          dout_reg  <= '0;
          valid_reg <= 1'b0;
        end else begin
          valid_reg <= rd_ok;
          if (rd_ok) dout_reg <= mem[rd_ptr_reg[ADDR_WIDTH-1:0]];
        end
      end
      assign data_out   = dout_reg;
      assign data_valid = valid_reg;
    end else begin : g_fwft
      // Head of the queue is presented combinationally; a pop only advances rd_ptr.
      assign data_out   = mem[rd_ptr_reg[ADDR_WIDTH-1:0]];
      assign data_valid = !fifo_empty;
    end
  endgenerate

endmodule

// File: tb/tb_prog_sync_fifo.sv
// Randomized self-checking bench: a standard and a FWFT instance share stimulus
// and are compared every cycle against a queue-based reference model.
module tb_prog_sync_fifo;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int DEPTH = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_req = 1'b0;
  logic          rd_req = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] data_in = '0;

  logic [DW-1:0] s_dout, f_dout;
  logic          s_dv, f_dv;
  logic          s_full, s_empty, s_af, s_ae, s_ov, s_un;
  logic          f_full, f_empty, f_af, f_ae, f_ov, f_un;
  logic [AW:0]   s_cnt, f_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];
  logic          m_ov = 1'b0;
  logic          m_un = 1'b0;
  logic          m_dv = 1'b0;
  logic [DW-1:0] m_dout = '0;

  always #5 clk = ~clk;

  prog_sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_req(wr_req), .data_in(data_in), .rd_req(rd_req), .clr_err(clr_err),
    .data_out(s_dout), .data_valid(s_dv), .fifo_full(s_full), .fifo_empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .fill_count(s_cnt), .overflow(s_ov), .underflow(s_un));

  prog_sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_req(wr_req), .data_in(data_in), .rd_req(rd_req), .clr_err(clr_err),
    .data_out(f_dout), .data_valid(f_dv), .fifo_full(f_full), .fifo_empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .fill_count(f_cnt), .overflow(f_ov), .underflow(f_un));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare at the falling edge.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                      input logic c, input logic rs);
    logic was_full, was_empty;
    int   n;
    wr_req = w; data_in = d; rd_req = r; clr_err = c; rst = rs;
    @(posedge clk);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (rs) begin
      q.delete();
      m_ov = 1'b0; m_un = 1'b0; m_dv = 1'b0; m_dout = '0;
    end else begin
      m_dv = 1'b0;
      if (r && !was_empty) begin
        m_dout = q.pop_front();
        m_dv = 1'b1;
      end
      if (w && !was_full) q.push_back(d);
      if (w && was_full) m_ov = 1'b1; else if (c) m_ov = 1'b0;
      if (r && was_empty) m_un = 1'b1; else if (c) m_un = 1'b0;
    end
    @(negedge clk);
    n = q.size();
    $display("t=%0t rst=%0b wr=%0b din=%02h rd=%0b clr=%0b -> cnt=%0d dv=%0b dout=%02h fdv=%0b fdout=%02h",
             $time, rs, w, d, r, c, s_cnt, s_dv, s_dout, f_dv, f_dout);
    check("count",        32'(s_cnt), 32'(n));
    check("fwft_count",   32'(f_cnt), 32'(n));
    check("full",         32'(s_full), 32'(n == DEPTH));
    check("empty",        32'(s_empty), 32'(n == 0));
    check("almost_full",  32'(s_af), 32'(n >= AF));
    check("almost_empty", 32'(s_ae), 32'(n <= AE));
    check("overflow",     32'(s_ov), 32'(m_ov));
    check("underflow",    32'(s_un), 32'(m_un));
    check("fwft_ovf",     32'(f_ov), 32'(m_ov));
    check("fwft_unf",     32'(f_un), 32'(m_un));
    check("data_valid",   32'(s_dv), 32'(m_dv));
    check("data_out",     32'(s_dout), 32'(m_dout));
    check("fwft_valid",   32'(f_dv), 32'(n != 0));
    if (n != 0) check("fwft_head", 32'(f_dout), 32'(q[0]));
  endtask

  initial begin
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    // Fill 0x10..0x17, overflow, drain, underflow, clear.
    for (int i = 0; i < DEPTH; i++) step(1, DW'(8'h10 + i), 0, 0, 0);
    step(1, 8'hEE, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    // Simultaneous requests at full, empty and mid-level.
    for (int i = 0; i < DEPTH; i++) step(1, DW'($urandom_range(0, 255)), 0, 0, 0);
    step(1, 8'h5A, 1, 0, 0);
    for (int i = 0; i < DEPTH - 1; i++) step(0, 0, 1, 0, 0);
    step(1, 8'h3C, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, DW'($urandom_range(0, 255)), 0, 0, 0);
    step(1, 8'h77, 1, 0, 0);
    // Wrap-around: 20 interleaved write/read pairs.
    for (int i = 0; i < 20; i++) begin
      if (i % 3 == 0) begin
        step(1, DW'($urandom_range(0, 255)), 0, 0, 0);
        step(0, 0, 1, 0, 0);
      end else begin
        step(1, DW'($urandom_range(0, 255)), 1, 0, 0);
      end
    end
    // Reset at count 5, then FWFT fall-through of 0xAB.
    while (q.size() < 5) step(1, DW'($urandom_range(0, 255)), 0, 0, 0);
    while (q.size() > 5) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    step(1, 8'hAB, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    // Error flag clear racing a new error.
    step(0, 0, 1, 1, 0);
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 55), DW'($urandom_range(0, 255)),
           1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 8),
           1'($urandom_range(0, 199) == 0));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_sync_fifo.md
PROG_SYNC_FIFO -- requirements
Module: prog_sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the data word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, with DEPTH = 2**ADDR_WIDTH entries.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-4, the almost-full threshold in entries.
REQ-004 SHALL have parameter AE_LEVEL, default 4, the almost-empty threshold in entries.
REQ-005 SHALL have parameter FWFT, default 0, selecting standard read mode (0) or first-word-fall-through mode (1).
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge triggered.
REQ-007 SHALL have port rst, input, 1 bit, reset, synchronous and active-high.
REQ-008 SHALL have port wr_req, input, 1 bit, write request.
REQ-009 SHALL have port data_in, input, DATA_WIDTH bits, write data.
REQ-010 SHALL have port rd_req, input, 1 bit, read request (a pop in FWFT mode).
REQ-011 SHALL have port clr_err, input, 1 bit, clears the sticky error flags.
REQ-012 SHALL have port data_out, output, DATA_WIDTH bits, read data.
REQ-013 SHALL have port data_valid, output, 1 bit, qualifying data_out.
REQ-014 SHALL have ports fifo_full, fifo_empty, almost_full and almost_empty, outputs, 1 bit each, status flags.
REQ-015 SHALL have port fill_count, output, ADDR_WIDTH+1 bits, number of stored entries (0..DEPTH).
REQ-016 SHALL have ports overflow and underflow, outputs, 1 bit each, sticky error flags.

Function
REQ-017 SHALL keep wr_ptr and rd_ptr at ADDR_WIDTH+1 bits each, using the low ADDR_WIDTH bits as the address and the MSB as the wrap bit; pointers wrap modulo 2*DEPTH.
REQ-018 SHALL accept a write when wr_req=1 and fifo_full=0: store data_in at mem[wr_ptr], then wr_ptr+1.
REQ-019 SHALL accept a read when rd_req=1 and fifo_empty=0: rd_ptr+1.
REQ-020 SHALL evaluate simultaneous requests against the pre-edge state: at full, the write is rejected and the read is accepted; at empty, the read is rejected and the write is accepted; otherwise both are accepted and fill_count is unchanged.
REQ-021 SHALL register fill_count: +1 on a write only, -1 on a read only, unchanged when both or neither are accepted.
REQ-022 SHALL derive the flags from the registered fill_count: fifo_full = (count==DEPTH), fifo_empty = (count==0), almost_full = (count>=AF_LEVEL), almost_empty = (count<=AE_LEVEL).
REQ-023 SHALL, when FWFT=0, register data_out <= mem[rd_ptr] on an accepted read, with data_valid=1 for exactly the following cycle; otherwise data_valid=0 and data_out holds its last value.
REQ-024 SHALL, when FWFT=1, drive data_out = mem[rd_ptr] and data_valid = !fifo_empty; an accepted rd_req pops, and the next head appears in the cycle after the pop edge.
REQ-025 SHALL, in FWFT mode, make a word written into an empty FIFO visible on data_out with data_valid=1 in the cycle after the write edge.
REQ-026 SHALL set overflow on a rejected write (wr_req=1 while fifo_full=1), and set underflow on a rejected read (rd_req=1 while fifo_empty=1).
REQ-027 SHALL clear overflow and underflow on clr_err=1; a new error in the same cycle wins, so the flag stays 1.
REQ-028 SHALL leave memory and pointers unchanged on rejected requests.
REQ-029 SHALL only accept AF_LEVEL and AE_LEVEL values in the range 1..DEPTH-1; other values are illegal configurations and the behaviour is undefined.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, set wr_ptr=0, rd_ptr=0 and fill_count=0, giving fifo_empty=1, almost_empty=1, fifo_full=0 and almost_full=0.
REQ-031 SHALL, on rst=1 at a clock edge, also set data_out=0, data_valid=0, overflow=0 and underflow=0.
REQ-032 SHALL give rst priority over all requests in the same cycle; memory contents are not reset, and a reset mid-operation discards all stored entries.

Verification (ADDR_WIDTH=3, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2)
REQ-033 SHALL cover fill and drain: write 8 words 0x10..0x17, then read 8 words -> fifo_full=1 after the 8th write; almost_full=1 from count 6; read data is 0x10..0x17 in order; fifo_empty=1 at the end.
REQ-034 SHALL cover overflow and underflow: a 9th write at full -> overflow=1 and count stays 8; a read at empty -> underflow=1; clr_err -> both flags 0.
REQ-035 SHALL cover simultaneous requests: at count 8 with wr_req and rd_req -> count 7 and the write is dropped; at count 0 with both -> count 1 and no data_valid pulse; at count 4 with both -> count stays 4.
REQ-036 SHALL cover wrap-around: 20 write/read pairs with interleaving -> pointers wrap past 15, data stays in order, and fill_count never exceeds 8.
REQ-037 SHALL cover FWFT=1: write 0xAB into an empty FIFO -> the next cycle shows data_out=0xAB and data_valid=1 with no rd_req; a pop -> data_valid=0.
REQ-038 SHALL cover reset mid-operation: assert rst at count 5 -> count=0, fifo_empty=1, data_valid=0, and the next write/read returns the new data only.
